// File: rtl/spi_receiver_pkg.sv
// Shared types and helpers for the SPI command receiver.
// A received byte is split into a 2-bit tag and a 6-bit payload.
package spi_receiver_pkg;

    localparam int BYTE_W    = 8;
    localparam int CNT_W     = 3;
    localparam int PAYLOAD_W = 6;

    typedef enum logic [1:0] {
        TAG_NOP    = 2'b00,
        TAG_SET    = 2'b01,
        TAG_TOGGLE = 2'b10,
        TAG_MATCH  = 2'b11
    } cmd_tag_e;

    typedef struct packed {
        cmd_tag_e               tag;
        logic [PAYLOAD_W-1:0]   payload;
    } cmd_t;

    function automatic cmd_t decode_byte(input logic [BYTE_W-1:0] b);
        cmd_t c;
        c.tag     = cmd_tag_e'(b[BYTE_W-1 -: 2]);
        c.payload = b[PAYLOAD_W-1:0];
        return c;
    endfunction

    // Next value of the status bit after executing one command.
    function automatic logic apply_cmd(input cmd_t c, input logic cur,
                                       input logic [PAYLOAD_W-1:0] key);
        logic nxt;
        nxt = cur;
        case (c.tag)
            TAG_NOP:    nxt = cur;
            TAG_SET:    nxt = c.payload[0];
            TAG_TOGGLE: nxt = ~cur;
            TAG_MATCH:  nxt = (c.payload == key);
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins, with rising-edge detect on sclk.
// cs_n resets to 1 so a reset never looks like an active frame.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [2:0] sclk_sr;
    logic [1:0] cs_sr;
    logic [1:0] mosi_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            cs_sr   <= {cs_sr[0], cs_n};
            mosi_sr <= {mosi_sr[0], mosi};
        end
    end

    // sclk_sr[2] is the previous synchronized value, used only for edge detect.
    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign cs_n_s    = cs_sr[1];
    assign mosi_s    = mosi_sr[1];

endmodule

// File: rtl/spi_receiver.sv
// Oversampled SPI mode-0 slave: assembles MSB-first bytes and applies each
// as a command to a single registered status bit.
module spi_receiver
    import spi_receiver_pkg::*;
#(
    parameter logic [PAYLOAD_W-1:0] KEY = 6'h2A
) (
    input  logic _i_clk,
    input  logic _i_rst,
    input  logic _i_sclk,
    input  logic _i_cs_n,
    input  logic _i_mosi,
    output logic __output
);

    logic              sclk_rise;
    logic              cs_n_s;
    logic              mosi_s;
    logic [BYTE_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              byte_valid;
    logic              status_q;
    cmd_t              cmd;

    spi_pin_sync u_sync (
        .clk       (_i_clk),
        .rst_n     (_i_rst),
        .sclk      (_i_sclk),
        .cs_n      (_i_cs_n),
        .mosi      (_i_mosi),
        .sclk_rise (sclk_rise),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s)
    );

    // The shift register doubles as the byte latch: once byte_valid fires it
    // holds the full byte until the next sclk rise, at least 3 clocks later.
    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_n_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[BYTE_W-2:0], mosi_s};
                bit_cnt   <= bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    assign cmd = decode_byte(shift_reg);

    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            status_q <= 1'b0;
        end else if (byte_valid) begin
            status_q <= apply_cmd(cmd, status_q, KEY);
        end
    end

    assign __output = status_q;

endmodule

// File: tb/tb_spi_receiver.sv
// Self-checking bench for spi_receiver: directed vector table, hand-written
// corner sequences, and random command streams against a reference model.
module tb_spi_receiver;

    logic clk = 1'b0;
    logic rstN;
    logic sclk;
    logic csN;
    logic mosi;
    logic statusOut;

    int vecCount  = 0;
    int missCount = 0;
    logic modelOut;

    typedef struct {
        logic [7:0] data;
        logic       newFrame;
        logic       expOut;
        string      name;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    spi_receiver #(.KEY(6'h2A)) dut (
        ._i_clk   (clk),
        ._i_rst   (rstN),
        ._i_sclk  (sclk),
        ._i_cs_n  (csN),
        ._i_mosi  (mosi),
        .__output (statusOut)
    );

    // Reference: tag is the top two bits, payload the low six.
    function automatic logic refNext(input logic cur, input logic [7:0] b);
        int tag;
        int payload;
        tag     = int'(b) / 64;
        payload = int'(b) % 64;
        case (tag)
            0:       return cur;
            1:       return (payload % 2) == 1;
            2:       return !cur;
            default: return payload == 42;
        endcase
    endfunction

    function automatic vec_t makeVec(input logic [7:0] d, input logic nf,
                                     input logic e, input string n);
        vec_t v;
        v.data = d;
        v.newFrame = nf;
        v.expOut = e;
        v.name = n;
        return v;
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expected);
        vecCount++;
        if (statusOut !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, statusOut, expected);
        end
    endtask

    // Shifts the top nBits of b, MSB first; optionally checks that the
    // output has not yet moved 3 clocks after the final sclk rise.
    task automatic applyBits(input logic [7:0] b, input int nBits,
                             input bit latencyCheck, input logic expBefore);
        for (int i = 7; i > 7 - nBits; i--) begin
            mosi = b[i];
            waitClk(4);
            sclk = 1'b1;
            if (latencyCheck && i == 0) begin
                waitClk(3);
                checkOutput("latencyEdge3", expBefore);
                waitClk(1);
            end else begin
                waitClk(4);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        applyBits(b, 8, 1'b0, 1'b0);
    endtask

    task automatic frameStart();
        csN = 1'b0;
        waitClk(4);
    endtask

    task automatic frameEnd();
        waitClk(4);
        csN = 1'b1;
        waitClk(4);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        int nb;

        vecs[0]  = makeVec(8'h41, 1'b1, 1'b1, "set");
        vecs[1]  = makeVec(8'h40, 1'b1, 1'b0, "clear");
        vecs[2]  = makeVec(8'h80, 1'b1, 1'b1, "toggle1");
        vecs[3]  = makeVec(8'h80, 1'b0, 1'b0, "toggle2SameFrame");
        vecs[4]  = makeVec(8'hEA, 1'b1, 1'b1, "matchHit");
        vecs[5]  = makeVec(8'h00, 1'b0, 1'b1, "nopKeep1");
        vecs[6]  = makeVec(8'hEB, 1'b1, 1'b0, "matchMiss");
        vecs[7]  = makeVec(8'h00, 1'b1, 1'b0, "nopKeep0");
        vecs[8]  = makeVec(8'h7F, 1'b1, 1'b1, "setIgnoresHigh");
        vecs[9]  = makeVec(8'h3F, 1'b0, 1'b1, "nopHighPayload");
        vecs[10] = makeVec(8'h7E, 1'b0, 1'b0, "setZero");
        vecs[11] = makeVec(8'hD5, 1'b1, 1'b0, "matchOtherPayload");
        vecs[12] = makeVec(8'hAA, 1'b1, 1'b1, "toggleKeyPayload");
        vecs[13] = makeVec(8'h6A, 1'b0, 1'b0, "setKeyPayload");
        vecs[14] = makeVec(8'hEA, 1'b1, 1'b1, "matchHit2");
        vecs[15] = makeVec(8'hC0, 1'b0, 1'b0, "matchZeroPayload");

        rstN = 1'b0;
        sclk = 1'b0;
        csN  = 1'b1;
        mosi = 1'b0;
        waitClk(3);
        checkOutput("inReset", 1'b0);
        rstN = 1'b1;
        for (int c = 0; c < 20; c++) begin
            waitClk(1);
            checkOutput("idleAfterReset", 1'b0);
        end

        // Directed table; the first entry also checks edge-3/edge-4 latency.
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || vecs[i].newFrame) begin
                if (csN == 1'b0) frameEnd();
                frameStart();
            end
            applyBits(vecs[i].data, 8, (i == 0), 1'b0);
            checkOutput(vecs[i].name, vecs[i].expOut);
        end
        frameEnd();
        checkOutput("afterTableFrameEnd", 1'b0);

        // Aborted frame: partial Set discarded, following Toggle executes.
        frameStart();
        applyBits(8'h41, 5, 1'b0, 1'b0);
        frameEnd();
        checkOutput("abortNoExec", 1'b0);
        frameStart();
        applyStimulus(8'h80);
        frameEnd();
        checkOutput("toggleAfterAbort", 1'b1);

        // sclk pulses with cs_n high must be ignored.
        applyStimulus(8'h80);
        waitClk(4);
        checkOutput("csHighIgnored", 1'b1);
        frameStart();
        applyStimulus(8'h40);
        checkOutput("countFreshAfterCsHigh", 1'b0);
        frameEnd();

        // Async reset in the middle of a frame while the output is 1.
        frameStart();
        applyStimulus(8'h41);
        checkOutput("setBeforeReset", 1'b1);
        applyBits(8'h41, 4, 1'b0, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncResetImmediate", 1'b0);
        csN = 1'b1;
        sclk = 1'b0;
        waitClk(3);
        rstN = 1'b1;
        waitClk(4);
        frameStart();
        applyStimulus(8'h41);
        frameEnd();
        checkOutput("setAfterReset", 1'b1);

        // Random command streams with random frame splits and aborts.
        modelOut = 1'b1;
        frameStart();
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                nb = $urandom_range(1, 7);
                applyBits(rb, nb, 1'b0, 1'b0);
                frameEnd();
                checkOutput("randAbort", modelOut);
                frameStart();
                rb = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 2) == 0) begin
                frameEnd();
                frameStart();
            end
            applyStimulus(rb);
            modelOut = refNext(modelOut, rb);
            checkOutput("randCmd", modelOut);
        end
        frameEnd();
        checkOutput("randFinal", modelOut);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/spi_receiver.md
# spi_receiver

Oversampled SPI slave (mode 0, MSB first) that receives 8-bit command bytes, decodes each byte into a tagged command, and applies it to a single registered status bit on `__output`. All SPI pins are asynchronous to `_i_clk` and are synchronized internally. The block sits at the edge of the design, turning an external SPI command stream into one control flag.

## Interface
- `KEY`, default 6'h2A: pattern compared by the Match command.
- `_i_clk` input 1: system clock; all state on rising edge.
- `_i_rst` input 1: asynchronous, active-low reset.
- `_i_sclk` input 1: SPI clock, asynchronous, idle low.
- `_i_cs_n` input 1: SPI chip select, asynchronous, active low.
- `_i_mosi` input 1: SPI data in, asynchronous.
- `__output` output 1: registered status bit.

## Operation
- Reset (while `_i_rst`=0): `__output`=0, bit counter=0, shift register=0, synchronizer flops=0 for sclk and mosi, 1 for cs_n.
- Each pin passes through a 2-flop synchronizer. A third sclk flop detects rising edges: synced sclk=1 and previous=0.
- Frame active while synced cs_n=0. On each sclk rising edge in an active frame, shift synced mosi into shift register LSB (MSB first on the wire), increment 3-bit counter.
- When counter wraps 7->0, the assembled byte is latched and `byte_valid` pulses for one cycle. Multiple bytes per cs_n-low frame are allowed; each executes independently.
- Synced cs_n=1: counter cleared, partial byte discarded, no command executed. Rising edges on sclk while cs_n high are ignored.
- Decode of byte b, tag b[7:6]:
  - 00 Nop: `__output` unchanged.
  - 01 Set: `__output` <= b[0]; b[5:1] ignored.
  - 10 Toggle: `__output` <= ~`__output`; b[5:0] ignored.
  - 11 Match: `__output` <= (b[5:0] == KEY).
- Reset mid-frame: all state returns to reset values immediately; the frame is lost.

## Timing
- Latency: a pin-level sclk rise is registered in sync flop 1 at edge 1 and flop 2 at edge 2. The edge is detected and the bit shifted at edge 3. For bit 7, `byte_valid` is set at edge 3 and `__output` updates at edge 4.
- Requirements on the SPI master:
  - sclk high and low phases each at least 3 `_i_clk` periods.
  - mosi stable from 1 `_i_clk` period before to 3 periods after the sclk rising edge.
  - cs_n falls at least 3 `_i_clk` periods before the first sclk rise.
  - cs_n rises at least 3 periods after the last sclk rise of a byte to be executed.
- Throughput: one command per 8 sclk periods; no back-pressure.

## Structure
- Shared package `spi_receiver_pkg`:
  - tag constants TAG_NOP=2'b00, TAG_SET=2'b01, TAG_TOGGLE=2'b10, TAG_MATCH=2'b11.
  - command enum/struct {tag, payload[5:0]}.
  - BYTE_W=8.
- Sub-module `spi_pin_sync`: 2-flop synchronizer plus edge detect for sclk, plain sync for cs_n and mosi. Reset values per Operation.
- Top: shift register/counter, decode, and output register.

## Test plan
- Reset: hold `_i_rst`=0 then release with pins idle (sclk=0, cs_n=1) -> `__output`=0 and stays 0 for 20 cycles.
- Set then clear: frame with byte 8'h41 -> `__output`=1 on the 4th clk after the 8th sclk rise. Then 8'h40 -> `__output`=0.
- Toggle twice in one frame: bytes 8'h80, 8'h80 under a single cs_n low -> `__output` goes 1 after byte 1, 0 after byte 2.
- Match: byte 8'hEA (payload 6'h2A) -> `__output`=1. Byte 8'hEB -> `__output`=0. Byte 8'h00 (Nop) -> unchanged.
- Aborted frame: 5 bits of 8'h41, then cs_n high, then a full 8'h80 -> the partial byte is discarded and the Toggle executes, so `__output`=1.
- Async reset mid-frame: `_i_rst`=0 after 4 bits while `__output`=1 -> `__output`=0 immediately. A following full 8'h41 frame -> `__output`=1.
